// File: rtl/prog_seq_fsm.sv
// -----------------------------------------------------------------------------
// prog_seq_fsm
// Programmable code sequencer. A small table of WIDTH-bit codes is stepped
// through forwards or backwards between index 0 and a programmable last index.
// It runs either as an endless loop or as a single pass.
//
// Ports
//   clk       : single clock, rising-edge active
//   rst       : asynchronous, active-low reset
//   start     : begin a run (accepted in IDLE only)
//   stop      : abort a run (accepted in RUN only, wins over en)
//   en        : step enable while running
//   dir       : step direction, 0 = forward, 1 = backward (sampled every step)
//   one_shot  : run mode, 0 = loop, 1 = single pass (latched on start)
//   wr_en     : table write strobe (IDLE only)
//   wr_addr   : table entry to write
//   wr_data   : table write data
//   last_we   : last-index load strobe (IDLE only)
//   last_in   : new last index
//   y         : registered code, table[idx]
//   idx       : current table index
//   busy      : high while running
//   wrap      : one-cycle pulse on every loop wrap
//   done      : one-cycle pulse when a single pass completes
// -----------------------------------------------------------------------------
module prog_seq_fsm #(
    parameter int WIDTH = 3,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic             one_shot,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             last_we,
    input  logic [AW-1:0]    last_in,
    output logic [WIDTH-1:0] y,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] tbl_d [DEPTH];
    logic [WIDTH-1:0] y_q, y_d;
    logic             one_shot_q, one_shot_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             at_end_s;

    // An enabled step at this index leaves the 0..last window in the current direction.
    assign at_end_s = dir ? (idx_q == {AW{1'b0}}) : (idx_q == last_q);

    // Next-state, table/last programming, index stepping and pulse generation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        one_shot_d = one_shot_q;
        wrap_d     = 1'b0;
        done_d     = 1'b0;
        tbl_d      = tbl_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    tbl_d[wr_addr] = wr_data;
                end else begin
                    tbl_d = tbl_q;
                end
                if (last_we) begin
                    last_d = last_in;
                end else begin
                    last_d = last_q;
                end
                // idx is only reloaded on start, so it may sit beyond a new last.
                if (start) begin
                    state_d    = ST_RUN;
                    idx_d      = dir ? last_q : {AW{1'b0}};
                    one_shot_d = one_shot;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (en) begin
                    if (at_end_s) begin
                        if (one_shot_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = dir ? last_q : {AW{1'b0}};
                            wrap_d = 1'b1;
                        end
                    end else begin
                        idx_d = dir ? (idx_q - AW'(1)) : (idx_q + AW'(1));
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reading the post-write table gives the read-after-write bypass on y.
        y_d = tbl_d[idx_d];
    end

    // State, index, table and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= {AW{1'b0}};
            last_q     <= AW'(DEPTH - 1);
            one_shot_q <= 1'b0;
            y_q        <= {WIDTH{1'b0}};
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= WIDTH'(i);
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            one_shot_q <= one_shot_d;
            y_q        <= y_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            tbl_q      <= tbl_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = (state_q == ST_RUN);
    assign wrap = wrap_q;
    assign done = done_q;

endmodule
